noc_demux2: RTL and testbench

// - 1-to-2 packet demultiplexer: the counterpart of the team's clocked MUX2. It steers one

---
 rtl/noc_demux2.sv | 134 +++++++++++++
 tb/tb_noc_demux2.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_demux2.sv
// ---------------------------------------------------------------------------
// noc_demux2 -- 1-to-2 packet demultiplexer with one FIFO per output port.
//
// One input stream is steered packet by packet to port 1 (in_select = 0) or
// port 2 (in_select = 1). Each port buffers packets in its own FIFO, so a
// stalled consumer on one port does not block traffic to the other port.
//
// Ports
//   clk                     single clock, all state on posedge
//   reset                   asynchronous, active-low
//   in_data/in_select       input packet and its destination port
//   in_valid/in_ready       input handshake; in_ready = ~full of selected FIFO
//   outN_data/outN_valid    head packet of port-N FIFO (data is 0 when empty)
//   outN_ready              port-N consumer takes the head at posedge
//   outN_count              packets accepted for port N, wraps silently
// ---------------------------------------------------------------------------

// Per-port FIFO: wrap-bit pointers, head masked to 0 while empty, and a
// counter of accepted pushes.
module noc_demux2_fifo #(
   parameter int W     = 4,
   parameter int DEPTH = 2,
   parameter int CW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic          full,
   output logic          head_valid,
   output logic [W-1:0]  head_data,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [AW:0]             wr_ptr, rd_ptr;
   logic                    empty, do_push, do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // Push is refused when full even if a pop happens the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign head_valid = !empty;
   assign head_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
            count               <= count + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

module noc_demux2 #(
   parameter int DATA_PACKET_SIZE = 4,
   parameter int FIFO_DEPTH       = 2,
   parameter int COUNT_WIDTH      = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_PACKET_SIZE-1:0] in_data,
   input  logic                        in_select,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [DATA_PACKET_SIZE-1:0] out1_data,
   output logic                        out1_valid,
   input  logic                        out1_ready,
   output logic [DATA_PACKET_SIZE-1:0] out2_data,
   output logic                        out2_valid,
   input  logic                        out2_ready,
   output logic [COUNT_WIDTH-1:0]      out1_count,
   output logic [COUNT_WIDTH-1:0]      out2_count
);
   localparam int NUM_PORTS = 2;

   logic [NUM_PORTS-1:0]                       push, pop, full, valid, ready;
   logic [NUM_PORTS-1:0][DATA_PACKET_SIZE-1:0] head;
   logic [NUM_PORTS-1:0][COUNT_WIDTH-1:0]      cnt;

   // Combinational: depends only on the addressed FIFO, not on in_valid
   // or on the same-cycle consumer ready.
   assign in_ready = in_select ? !full[1] : !full[0];

   assign ready = {out2_ready, out1_ready};

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign push[p] = in_valid && in_ready && (in_select == 1'(p));
      assign pop[p]  = valid[p] && ready[p];

      noc_demux2_fifo #(
         .W     (DATA_PACKET_SIZE),
         .DEPTH (FIFO_DEPTH),
         .CW    (COUNT_WIDTH)
      ) u_fifo (
         .clk        (clk),
         .reset      (reset),
         .push       (push[p]),
         .push_data  (in_data),
         .pop        (pop[p]),
         .full       (full[p]),
         .head_valid (valid[p]),
         .head_data  (head[p]),
         .count      (cnt[p])
      );
   end

   assign out1_data  = head[0];
   assign out1_valid = valid[0];
   assign out1_count = cnt[0];
   assign out2_data  = head[1];
   assign out2_valid = valid[1];
   assign out2_count = cnt[1];

   // A request with an unknown destination cannot be routed.
   always @(posedge clk) begin
      if (reset && in_valid)
         assert (!$isunknown(in_select));
   end
endmodule

// File: tb/tb_noc_demux2.sv
// Bench for noc_demux2: a driver issues requests and pushes accepted packets
// into per-port expected queues; independent monitors compare DUT outputs
// against the queue heads and the accepted-packet tallies. A second instance
// with 2-bit counters shares all inputs to cover counter wrap.
module tb_noc_demux2;
   localparam int W  = 4;
   localparam int D  = 2;
   localparam int CW = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_select = 1'b0;
   logic         in_valid = 1'b0;
   logic         out1_ready = 1'b0;
   logic         out2_ready = 1'b0;

   logic          in_ready, out1_valid, out2_valid;
   logic [W-1:0]  out1_data, out2_data;
   logic [CW-1:0] out1_count, out2_count;

   logic          w_in_ready, w_out1_valid, w_out2_valid;
   logic [W-1:0]  w_out1_data, w_out2_data;
   logic [1:0]    w_out1_count, w_out2_count;

   always #5 clk = ~clk;

   noc_demux2 #(.DATA_PACKET_SIZE(W), .FIFO_DEPTH(D), .COUNT_WIDTH(CW)) u_dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_select(in_select),
      .in_valid(in_valid), .in_ready(in_ready),
      .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
      .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
      .out1_count(out1_count), .out2_count(out2_count));

   noc_demux2 #(.DATA_PACKET_SIZE(W), .FIFO_DEPTH(D), .COUNT_WIDTH(2)) u_dut_w (
      .clk(clk), .reset(reset), .in_data(in_data), .in_select(in_select),
      .in_valid(in_valid), .in_ready(w_in_ready),
      .out1_data(w_out1_data), .out1_valid(w_out1_valid), .out1_ready(out1_ready),
      .out2_data(w_out2_data), .out2_valid(w_out2_valid), .out2_ready(out2_ready),
      .out1_count(w_out1_count), .out2_count(w_out2_count));

   // Reference model: per-port packet queues and accepted-packet tallies.
   logic [W-1:0] q1[$];
   logic [W-1:0] q2[$];
   int           c1 = 0;
   int           c2 = 0;
   int           tests = 0;
   int           fails = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Pop monitor: every handshake on an output must match the queue head.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (out1_valid && out1_ready) begin
            if (q1.size() == 0) begin
               tests++; fails++;
               $display("FAIL pop1: got packet %0h expected none", out1_data);
            end else begin
               logic [W-1:0] e1;
               e1 = q1.pop_front();
               chk("pop1 data", 32'(out1_data), 32'(e1));
            end
         end
         if (out2_valid && out2_ready) begin
            if (q2.size() == 0) begin
               tests++; fails++;
               $display("FAIL pop2: got packet %0h expected none", out2_data);
            end else begin
               logic [W-1:0] e2;
               e2 = q2.pop_front();
               chk("pop2 data", 32'(out2_data), 32'(e2));
            end
         end
      end
   end

   // State monitor: after each edge the outputs must reflect model contents.
   always @(posedge clk) begin
      #2;
      if (reset === 1'b1) begin
         chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
         chk("out2_valid", 32'(out2_valid), 32'(q2.size() != 0));
         chk("out1_data", 32'(out1_data), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
         chk("out2_data", 32'(out2_data), (q2.size() != 0) ? 32'(q2[0]) : 32'd0);
         chk("w_out2_data", 32'(w_out2_data), (q2.size() != 0) ? 32'(q2[0]) : 32'd0);
         chk("out1_count", 32'(out1_count), 32'(c1 % 256));
         chk("out2_count", 32'(out2_count), 32'(c2 % 256));
         chk("w_out1_count", 32'(w_out1_count), 32'(c1 % 4));
         chk("w_out2_count", 32'(w_out2_count), 32'(c2 % 4));
      end
   end

   // One cycle of stimulus; acc reports whether the request was taken.
   task automatic step(input logic v, input logic [W-1:0] d, input logic s,
                       input logic r1, input logic r2, output logic acc);
      int occ;
      @(posedge clk);
      #1;
      in_valid = v; in_data = d; in_select = s; out1_ready = r1; out2_ready = r2;
      #1;
      occ = s ? q2.size() : q1.size();
      chk("in_ready", 32'(in_ready), 32'(occ < D));
      chk("w_in_ready", 32'(w_in_ready), 32'(occ < D));
      @(negedge clk);
      acc = v && in_ready;
      if (acc) begin
         if (s) begin q2.push_back(d); c2++; end
         else   begin q1.push_back(d); c1++; end
      end
   endtask

   task automatic idle(input logic r1, input logic r2);
      logic a;
      step(1'b0, '0, 1'b0, r1, r2, a);
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic do_reset();
      @(posedge clk);
      #3;
      reset = 1'b0;
      in_valid = 1'b0;
      q1.delete(); q2.delete();
      c1 = 0; c2 = 0;
      #1;
      chk("rst out1_valid", 32'(out1_valid), 32'd0);
      chk("rst out2_valid", 32'(out2_valid), 32'd0);
      chk("rst out1_data", 32'(out1_data), 32'd0);
      chk("rst out2_data", 32'(out2_data), 32'd0);
      chk("rst out1_count", 32'(out1_count), 32'd0);
      chk("rst out2_count", 32'(out2_count), 32'd0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       a;
      logic [4:0] pairs[32];
      logic [1:0] wrap_exp[5];
      logic [4:0] tmp;
      int         j;

      #1;
      chk("init out1_valid", 32'(out1_valid), 32'd0);
      chk("init out2_count", 32'(out2_count), 32'd0);
      @(posedge clk);
      #3 reset = 1'b1;

      // T2 routing and latency
      step(1'b1, 4'h3, 1'b0, 1'b1, 1'b1, a);
      step(1'b1, 4'hA, 1'b1, 1'b1, 1'b1, a);
      chk("T2 out1_data", 32'(out1_data), 32'h3);
      idle(1'b1, 1'b1);
      chk("T2 out2_data", 32'(out2_data), 32'hA);
      chk("T2 out1_valid", 32'(out1_valid), 32'd0);
      chk("T2 out1_count", 32'(out1_count), 32'd1);
      chk("T2 out2_count", 32'(out2_count), 32'd1);
      idle(1'b1, 1'b1);

      // T3 full and backpressure
      step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, a);
      step(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, a);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, a);
      chk("T3 in_ready sel0", 32'(in_ready), 32'd0);
      step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, a);
      chk("T3 in_ready sel1", 32'(in_ready), 32'd1);
      step(1'b1, 4'h7, 1'b1, 1'b0, 1'b0, a);
      step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, a);
      chk("T3 out2_data", 32'(out2_data), 32'h7);

      // T4 full FIFO with a pop in the same cycle: pop only, then accept
      step(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, a);
      chk("T4 refused while full", 32'(a), 32'd0);
      step(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, a);
      chk("T4 accepted after pop", 32'(a), 32'd1);
      repeat (4) idle(1'b1, 1'b1);
      chk("T4 drained", 32'(out1_valid), 32'd0);

      // T1 reset mid-stream with both FIFOs holding two packets
      step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, a);
      step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, a);
      step(1'b1, 4'h8, 1'b1, 1'b0, 1'b0, a);
      step(1'b1, 4'h4, 1'b1, 1'b0, 1'b0, a);
      idle(1'b0, 1'b0);
      chk("T1 pre out2_valid", 32'(out2_valid), 32'd1);
      do_reset();
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, a);
      chk("T1 in_ready sel0", 32'(in_ready), 32'd1);
      step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, a);
      chk("T1 in_ready sel1", 32'(in_ready), 32'd1);

      // T5 every (data, select) pair in random order, random consumer ready
      do_reset();
      for (int i = 0; i < 32; i++) pairs[i] = 5'(i);
      for (int i = 31; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         tmp = pairs[i]; pairs[i] = pairs[j]; pairs[j] = tmp;
      end
      for (int i = 0; i < 32; i++) begin
         a = 1'b0;
         for (int k = 0; k < 100 && !a; k++)
            step(1'b1, pairs[i][3:0], pairs[i][4],
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
         if (!a) begin
            tests++; fails++;
            $display("FAIL T5 accept: got stuck expected acceptance of %0h", pairs[i]);
         end
      end
      repeat (6) idle(1'b1, 1'b1);
      chk("T5 out1_count", 32'(out1_count), 32'd16);
      chk("T5 out2_count", 32'(out2_count), 32'd16);
      chk("T5 out1_valid", 32'(out1_valid), 32'd0);
      chk("T5 out2_valid", 32'(out2_valid), 32'd0);

      // T6 2-bit counter wraps on port 2
      do_reset();
      wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
      wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
      for (int i = 0; i < 6; i++) begin
         step(i < 5, 4'(i), 1'b1, 1'b1, 1'b1, a);
         if (i > 0) chk("T6 w_out2_count", 32'(w_out2_count), 32'(wrap_exp[i-1]));
      end
      repeat (3) idle(1'b1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
